// File: rtl/mem_stream.sv
// DEPTH x WIDTH RAM with one write port and a streaming read engine that emits
// `length` consecutive words from base_addr through a 2-entry skid buffer.
module mem_stream #(
    parameter int    WIDTH      = 32,
    parameter int    ADDR_WIDTH = 7,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  dout_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      rd_data_q;

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic                  rd_last_q,   rd_last_d;
    logic [WIDTH-1:0]      fifo_data_q [2];
    logic [WIDTH-1:0]      fifo_data_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic [1:0]            fifo_cnt_q,  fifo_cnt_d;
    logic                  done_q,      done_d;

    logic [1:0]            occ;
    logic                  pop;
    logic                  space;
    logic                  rd_en;

    // NOTE: the RAM has no reset so it maps onto block RAM; reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking read and write in separate processes give read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Output comes from the buffer head, or straight from the RAM register when the buffer is empty.
    always_comb begin
        dout_valid = (fifo_cnt_q != 2'd0) || rd_valid_q;
        if (fifo_cnt_q != 2'd0) begin
            dout      = fifo_data_q[0];
            dout_last = fifo_last_q[0];
        end else if (rd_valid_q) begin
            dout      = rd_data_q;
            dout_last = rd_last_q;
        end else begin
            dout      = '0;
            dout_last = 1'b0;
        end
        busy = (state_q != IDLE);
        done = done_q;
    end

    // A read may issue only if the word can still be stored after this cycle's pop.
    assign pop   = dout_valid && dout_ready;
    assign occ   = fifo_cnt_q + {1'b0, rd_valid_q};
    assign space = (occ - {1'b0, pop}) < 2'd2;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = RUN;
                        rd_ptr_d    = base_addr;
                        remaining_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (space) begin
                    rd_en       = 1'b1;
                    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && dout_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = rd_en;
        rd_last_d  = rd_en ? (remaining_q == (ADDR_WIDTH+1)'(1)) : rd_last_q;
    end

    // Skid buffer: pop shifts the head out, then a pending RAM word lands in the next free slot.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (pop && (fifo_cnt_q != 2'd0)) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            fifo_cnt_d     = fifo_cnt_q - 2'd1;
        end
        if (rd_valid_q && !(pop && (fifo_cnt_q == 2'd0))) begin
            fifo_data_d[fifo_cnt_d[0]] = rd_data_q;
            fifo_last_d[fifo_cnt_d[0]] = rd_last_q;
            fifo_cnt_d                 = fifo_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            fifo_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            done_q      <= done_d;
        end
    end

endmodule
